// File: rtl/seq_det_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_det_sched_pkg
// Purpose : Shared types and constants for the time-shared sequence detector
//           scheduler: channel count, control FSM state encoding, per-channel
//           detector context type and the round-robin pick helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package seq_det_sched_pkg;

  localparam int NCH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Saved Mealy detector state for one channel.
  typedef struct packed {
    logic a;
    logic b;
  } ctx_t;

  // First set request at or after pointer p, wrapping 3 -> 0. Scanning from
  // the farthest position back to p leaves the nearest hit in sel.
  function automatic logic [1:0] rr_pick(input logic [NCH-1:0] r,
                                         input logic [1:0]     p);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = p;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) sel = idx;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : seq_det_sched_if
// Purpose : Request/data/grant bundle between the requesters and the
//           scheduler.
// Ports   : req[3:0], x_in[3:0] (requester -> scheduler)
//           gnt[3:0], match, match_ch[1:0], busy (scheduler -> requester)
//           modport master = requester side, slave = scheduler side
// Rev     : 1.0  initial release
// ============================================================================
interface seq_det_sched_if
  import seq_det_sched_pkg::*;
  ();

  logic [NCH-1:0] req;
  logic [NCH-1:0] x_in;
  logic [NCH-1:0] gnt;
  logic           match;
  logic [1:0]     match_ch;
  logic           busy;

  modport master (
    output req, x_in,
    input  gnt, match, match_ch, busy
  );

  modport slave (
    input  req, x_in,
    output gnt, match, match_ch, busy
  );

endinterface
`default_nettype wire

// File: rtl/seq_det_sched_core.sv
`default_nettype none
// ============================================================================
// Module  : mealy_det_core
// Purpose : Purely combinational 2-bit Mealy detector step. Given the current
//           context {a,b} and input bit x, produces the next context and y.
// Ports   : i_s (ctx_t) current context, i_x input bit,
//           o_s_next (ctx_t) next context, o_y detector output
// Rev     : 1.0  initial release
// ============================================================================
module mealy_det_core
  import seq_det_sched_pkg::*;
  (
    input  ctx_t i_s,
    input  logic i_x,
    output ctx_t o_s_next,
    output logic o_y
  );

  always_comb begin
    o_y        = (~i_x & i_s.b) | (i_s.a & i_x);
    o_s_next.a = ~i_x & i_s.b;
    o_s_next.b = i_x & ~i_s.a;
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module  : seq_det_sched
// Purpose : Round-robin scheduler time-sharing one Mealy detector across four
//           serial channels. Each channel keeps its own saved detector
//           context so bursts resume exactly where they left off.
// Ports   : clk  - clock, all state on rising edge
//           rst  - synchronous active-high reset
//           bus  - seq_det_sched_if.slave (req, x_in in; gnt, match,
//                  match_ch, busy out)
// Params  : BURST - max bits consumed per grant (2..16)
// Rev     : 1.0  initial release
// ============================================================================
module seq_det_sched
  import seq_det_sched_pkg::*;
  #(
    parameter int BURST = 8
  ) (
    input  logic            clk,
    input  logic            rst,
    seq_det_sched_if.slave  bus
  );

  localparam int CNT_W = 5;

  state_t         state_q, state_d;
  logic [1:0]     g_q, g_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic           match_q, match_d;
  logic [1:0]     match_ch_q, match_ch_d;
  ctx_t           ctx_q [NCH];
  ctx_t           ctx_d [NCH];

  logic           w_consume;
  logic           w_last;
  logic           w_leave;
  logic [1:0]     w_pick;
  ctx_t           w_det_next;
  logic           w_det_y;

  // A bit is consumed only while granted and the granted channel presents one.
  assign w_consume = (state_q == GRANT) && bus.req[g_q];
  assign w_last    = w_consume && (cnt_q == CNT_W'(BURST - 1));
  assign w_leave   = (state_q == GRANT) && (!bus.req[g_q] || w_last);
  assign w_pick    = rr_pick(bus.req, ptr_q);

  mealy_det_core u_core (
    .i_s      (ctx_q[g_q]),
    .i_x      (bus.x_in[g_q]),
    .o_s_next (w_det_next),
    .o_y      (w_det_y)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      g_q        <= 2'd0;
      ptr_q      <= 2'd0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      match_q    <= 1'b0;
      match_ch_q <= 2'd0;
      for (int i = 0; i < NCH; i++) ctx_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      match_q    <= match_d;
      match_ch_q <= match_ch_d;
      for (int i = 0; i < NCH; i++) ctx_q[i] <= ctx_d[i];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req) state_d = GRANT;
      GRANT:   if (w_leave)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    g_d        = g_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    match_d    = 1'b0;
    match_ch_d = match_ch_q;
    for (int i = 0; i < NCH; i++) ctx_d[i] = ctx_q[i];

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          g_d   = w_pick;
          gnt_d = NCH'(1) << w_pick;
          cnt_d = '0;
        end else begin
          gnt_d = '0;
        end
      end
      GRANT: begin
        if (w_consume) begin
          cnt_d      = cnt_q + CNT_W'(1);
          match_d    = w_det_y;
          match_ch_d = g_q;
          ctx_d[g_q] = w_det_next;
        end
        // Dropping gnt here yields the one-cycle bubble spent in IDLE.
        if (w_leave) begin
          gnt_d = '0;
          ptr_d = g_q + 2'd1;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.match    = match_q;
  assign bus.match_ch = match_ch_q;
  assign bus.busy     = (state_q == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_det_sched
// Purpose : Directed self-checking bench for seq_det_sched.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_det_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_det_sched_if bus ();

  seq_det_sched #(.BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] exp_g;
  int         ch;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req  = 4'b0000;
    bus.x_in = 4'b0000;

    // Reset state
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_match", 32'(bus.match), 32'h0);
    check("rst_mch", 32'(bus.match_ch), 32'h0);
    rst = 1'b0;

    // Channel 0 alone, bits 1,0,1,1 -> match 0,1,1,0
    bus.req  = 4'b0001;
    bus.x_in = 4'b0001;
    tick();
    check("c0_gnt", 32'(bus.gnt), 32'h1);
    check("c0_busy", 32'(bus.busy), 32'h1);
    tick();
    check("c0_m1", 32'(bus.match), 32'h0);
    check("c0_ch1", 32'(bus.match_ch), 32'h0);
    bus.x_in = 4'b0000;
    tick();
    check("c0_m2", 32'(bus.match), 32'h1);
    bus.x_in = 4'b0001;
    tick();
    check("c0_m3", 32'(bus.match), 32'h1);
    tick();
    check("c0_m4", 32'(bus.match), 32'h0);
    bus.req = 4'b0000;
    tick();
    check("c0_drop_gnt", 32'(bus.gnt), 32'h0);
    check("c0_drop_busy", 32'(bus.busy), 32'h0);
    check("c0_drop_m", 32'(bus.match), 32'h0);

    // Channel 1 burst of zeros (pointer now 1), then ch0 resumes from ctx 01
    bus.req  = 4'b0011;
    bus.x_in = 4'b0000;
    tick();
    check("c1_gnt", 32'(bus.gnt), 32'h2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("c1_m", 32'(bus.match), 32'h0);
      check("c1_mch", 32'(bus.match_ch), 32'h1);
      check("c1_burst_gnt", 32'(bus.gnt), (k < 8) ? 32'h2 : 32'h0);
    end
    tick();
    check("c0r_gnt", 32'(bus.gnt), 32'h1);
    check("c0r_m_idle", 32'(bus.match), 32'h0);
    check("c0r_mch_hold", 32'(bus.match_ch), 32'h1);
    tick();
    check("c0r_m", 32'(bus.match), 32'h1);
    check("c0r_mch", 32'(bus.match_ch), 32'h0);
    bus.req = 4'b0000;
    tick();

    // All four requesting: round robin, 8 cycles each, 1-cycle gap
    do_reset();
    bus.req  = 4'b1111;
    bus.x_in = 4'b0000;
    tick();
    ch = 0;
    check("rr_first", 32'(bus.gnt), 32'h1);
    for (int b = 0; b < 5; b++) begin
      exp_g = 4'b0001 << ch;
      for (int k = 1; k <= 8; k++) begin
        tick();
        check("rr_hold", 32'(bus.gnt), (k < 8) ? 32'(exp_g) : 32'h0);
      end
      if (b < 4) begin
        ch = (ch + 1) % 4;
        exp_g = 4'b0001 << ch;
        tick();
        check("rr_next", 32'(bus.gnt), 32'(exp_g));
      end
    end

    // Channel 2 drops request after 3 bits; pointer moves to 3
    do_reset();
    bus.req = 4'b0100;
    tick();
    check("c2_gnt", 32'(bus.gnt), 32'h4);
    tick();
    bus.req = 4'b0101;
    tick();
    bus.req = 4'b0110;
    tick();
    check("c2_hold", 32'(bus.gnt), 32'h4);
    bus.req = 4'b1001;
    tick();
    check("c2_drop_gnt", 32'(bus.gnt), 32'h0);
    check("c2_drop_busy", 32'(bus.busy), 32'h0);
    check("c2_drop_m", 32'(bus.match), 32'h0);
    tick();
    check("c2_next_c3", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0000;
    tick();

    // Reset on bit 5 of a burst with a nonzero context
    do_reset();
    bus.req  = 4'b0001;
    bus.x_in = 4'b0001;
    tick();
    for (int k = 0; k < 4; k++) tick();
    bus.x_in = 4'b0000;
    rst = 1'b1;
    tick();
    check("rst_mid_gnt", 32'(bus.gnt), 32'h0);
    check("rst_mid_m", 32'(bus.match), 32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    bus.req = 4'b0011;
    tick();
    check("rst_mid_c0", 32'(bus.gnt), 32'h1);
    tick();
    check("rst_mid_ctx", 32'(bus.match), 32'h0);
    bus.req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
